uart_tx_param: RTL and testbench

Parametrised UART transmitter: serialises a parallel word into a start bit, 5–9 data bits (LSB first), optional odd/even parity and 1 or 2 stop bits. The baud rate comes from an internal enable counter on the system clock, with no derived clock. A one-entry holding register allows back-to-back frames with no idle gap on the line. It sits between a byte-stream source (valid/ready) and the serial pin, replacing the fixed 8N1 transmitter in new designs.

---
 rtl/uart_tx_param.sv | 159 +++++++++++++++
 tb/tb_uart_tx_param.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, 5..9 data bits LSB first, optional parity, 1 or 2 stop bits.
// Latency: the start bit appears on tx one cycle after the tx_valid/tx_ready handshake.
// Backpressure: a one-word holding register; tx_ready stays low while it is full, so a further word waits.
module uart_tx_param #(
  parameter int CLK_DIV   = 868,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int CW = 4;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t                 state, state_n;
  logic [BW-1:0]          baud, baud_n;
  logic [CW-1:0]          bit_cnt, bit_n;
  logic [DATA_BITS-1:0]   shift, shift_n;
  logic                   par_bit, par_n;
  logic [DATA_BITS-1:0]   hold;
  logic                   hold_full;
  logic                   take;
  logic                   tx_n;
  logic                   bit_end;

  // Parity over the data bits: even = plain XOR, odd = inverted XOR.
  function automatic logic calc_par(input logic [DATA_BITS-1:0] w);
    return (PARITY == 1) ? ~(^w) : (^w);
  endfunction

  assign bit_end  = (baud == BAUD_LAST);
  assign tx_ready = ~hold_full;
  assign tx_busy  = (state != S_IDLE);

  // Holding register: filled on handshake, drained when the FSM starts a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (take) begin
      hold_full <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      hold      <= tx_data;
      hold_full <= 1'b1;
    end
  end

  // Frame state, baud/bit counters, shifter and the registered serial line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
      par_bit <= par_n;
      tx      <= tx_n;
    end
  end

  // Next-state logic; tx is derived from the next state so the line is registered with no extra cycle.
  always_comb begin
    state_n = state;
    baud_n  = (state == S_IDLE || bit_end) ? '0 : baud + 1'b1;
    bit_n   = bit_cnt;
    shift_n = shift;
    par_n   = par_bit;
    take    = 1'b0;
    case (state)
      S_IDLE: begin
        if (hold_full) begin
          take    = 1'b1;
          state_n = S_START;
          baud_n  = '0;
          bit_n   = '0;
          shift_n = hold;
          par_n   = calc_par(hold);
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          bit_n   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_n = shift >> 1;
          if (bit_cnt == LAST_DATA) begin
            state_n = (PARITY != 0) ? S_PAR : S_STOP;
            bit_n   = '0;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_n = S_STOP;
          bit_n   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt == LAST_STOP) begin
            bit_n = '0;
            // A waiting word goes straight into its start bit, no idle cycle.
            if (hold_full) begin
              take    = 1'b1;
              state_n = S_START;
              baud_n  = '0;
              shift_n = hold;
              par_n   = calc_par(hold);
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shift_n[0];
      S_PAR:   tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations (8N1, 7E2, 7O1 at 4 clk/bit, 9O1 at 5 clk/bit).
// A reference model predicts each frame's start cycle and bit pattern from the handshake time;
// a monitor compares the line, tx_busy and tx_ready every cycle against those predictions.
module tb_uart_tx_param;

  localparam int ND = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tv  [ND];
  logic [7:0] d0;
  logic [6:0] d1;
  logic [6:0] d2;
  logic [8:0] d3;
  logic       rdy [ND];
  logic       txl [ND];
  logic       bsy [ND];

  int   cyc = 0;
  logic done = 1'b0;
  logic stall_to = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   last_end [ND];

  typedef struct {
    int          hs;
    int          start;
    logic [15:0] bits;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_valid(tv[0]), .tx_data(d0),
    .tx_ready(rdy[0]), .tx(txl[0]), .tx_busy(bsy[0]));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .tx_valid(tv[1]), .tx_data(d1),
    .tx_ready(rdy[1]), .tx(txl[1]), .tx_busy(bsy[1]));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .tx_valid(tv[2]), .tx_data(d2),
    .tx_ready(rdy[2]), .tx(txl[2]), .tx_busy(bsy[2]));
  uart_tx_param #(.CLK_DIV(5), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) u3 (
    .clk(clk), .rst(rst), .tx_valid(tv[3]), .tx_data(d3),
    .tx_ready(rdy[3]), .tx(txl[3]), .tx_busy(bsy[3]));

  function automatic int cdiv(int d);
    return (d == 3) ? 5 : 4;
  endfunction
  function automatic int dbits(int d);
    case (d)
      0: return 8;
      3: return 9;
      default: return 7;
    endcase
  endfunction
  function automatic int pmode(int d);
    case (d)
      1: return 2;
      2: return 1;
      3: return 1;
      default: return 0;
    endcase
  endfunction
  function automatic int sbits(int d);
    return (d == 1) ? 2 : 1;
  endfunction
  function automatic int flen(int d);
    return (1 + dbits(d) + ((pmode(d) != 0) ? 1 : 0) + sbits(d)) * cdiv(d);
  endfunction

  // Expected bit sequence of one frame: index 0 is the start bit, stops default to 1.
  function automatic logic [15:0] frame_bits(int d, logic [8:0] w);
    logic [15:0] b;
    int n;
    int ones;
    b    = '1;
    n    = dbits(d);
    ones = 0;
    b[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      b[1 + i] = w[i];
      if (w[i]) ones++;
    end
    if (pmode(d) != 0) b[1 + n] = (pmode(d) == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    return b;
  endfunction

  function automatic int qsize(int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction
  function automatic exp_t qget(int d, int i);
    case (d)
      0: return q0[i];
      1: return q1[i];
      2: return q2[i];
      default: return q3[i];
    endcase
  endfunction

  task automatic set_in(int d, logic v, logic [8:0] w);
    case (d)
      0: begin tv[0] = v; d0 = w[7:0]; end
      1: begin tv[1] = v; d1 = w[6:0]; end
      2: begin tv[2] = v; d2 = w[6:0]; end
      default: begin tv[3] = v; d3 = w; end
    endcase
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a word after 'gap' cycles, hold it until accepted, record the predicted frame.
  task automatic send(int d, logic [8:0] w, int gap);
    exp_t e;
    logic [8:0] wm;
    int c;
    int lim;
    bit ok;
    wm = w;
    for (int i = dbits(d); i < 9; i++) wm[i] = 1'b0;
    idle(gap);
    set_in(d, 1'b1, wm);
    ok  = 1'b0;
    lim = 3 * flen(d) + 10;
    for (int t = 0; t < lim && !ok; t++) begin
      if (rdy[d]) begin
        c       = cyc + 1;
        e.hs    = c;
        e.start = (c + 1 > last_end[d]) ? c + 1 : last_end[d];
        e.bits  = frame_bits(d, wm);
        last_end[d] = e.start + flen(d);
        case (d)
          0: q0.push_back(e);
          1: q1.push_back(e);
          2: q2.push_back(e);
          default: q3.push_back(e);
        endcase
        ok = 1'b1;
      end
      @(negedge clk);
    end
    if (!ok) stall_to = 1'b1;
    set_in(d, 1'b0, 9'($urandom));
  endtask

  task automatic chk(string nm, int d, logic act, logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0b want=%0b", nm, d, cyc, act, want);
    end
  endtask

  task automatic chk_int(string nm, int d, int act, int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s dut%0d got=%0d want=%0d", nm, d, act, want);
    end
  endtask

  // Monitor: cycle-accurate comparison of every DUT against the predicted frames.
  initial begin
    exp_t cur [ND];
    exp_t e;
    bit   inf [ND];
    int   rd  [ND];
    int   k;
    logic ex;
    logic rprev;
    for (int d = 0; d < ND; d++) begin
      inf[d] = 1'b0;
      rd[d]  = 0;
    end
    #3;
    for (int d = 0; d < ND; d++) begin
      chk("reset_tx", d, txl[d], 1'b1);
      chk("reset_ready", d, rdy[d], 1'b1);
      chk("reset_busy", d, bsy[d], 1'b0);
    end
    rprev = rst;
    while (!done) begin
      @(negedge clk or negedge rst);
      if (!rst && rprev) begin
        #1;
        for (int d = 0; d < ND; d++) begin
          chk("async_rst_tx", d, txl[d], 1'b1);
          chk("async_rst_ready", d, rdy[d], 1'b1);
          chk("async_rst_busy", d, bsy[d], 1'b0);
          inf[d] = 1'b0;
          rd[d]  = qsize(d);
        end
      end else if (rst) begin
        for (int d = 0; d < ND; d++) begin
          if (!inf[d] && rd[d] < qsize(d)) begin
            e = qget(d, rd[d]);
            if (e.start == cyc) begin
              cur[d] = e;
              inf[d] = 1'b1;
              rd[d]++;
            end
          end
          if (inf[d]) begin
            k = cyc - cur[d].start;
            chk("tx_bit", d, txl[d], cur[d].bits[k / cdiv(d)]);
            chk("busy_frame", d, bsy[d], 1'b1);
            if (k == flen(d) - 1) inf[d] = 1'b0;
          end else begin
            chk("tx_idle", d, txl[d], 1'b1);
            chk("busy_idle", d, bsy[d], 1'b0);
          end
          ex = 1'b1;
          for (int j = rd[d]; j < qsize(d); j++) begin
            e = qget(d, j);
            if (e.hs <= cyc && e.start > cyc) ex = 1'b0;
          end
          chk("ready", d, rdy[d], ex);
        end
      end
      rprev = rst;
    end
    for (int d = 0; d < ND; d++) chk_int("frames_seen", d, rd[d], qsize(d));
    chk("no_stall", 0, stall_to, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Stimulus: directed frames from the plan, a mid-frame reset, then randomized traffic.
  initial begin
    int g;
    for (int d = 0; d < ND; d++) begin
      set_in(d, 1'b0, 9'h0);
      last_end[d] = 0;
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(5);
    send(0, 9'h0A5, 0);
    idle(50);
    send(1, 9'h053, 0);
    idle(60);
    send(2, 9'h053, 0);
    idle(50);
    send(0, 9'h001, 0);
    send(0, 9'h0FF, 0);
    send(0, 9'h03C, 0);
    idle(100);
    send(0, 9'h001, 0);
    send(0, 9'h081, 40);
    idle(60);
    send(3, 9'h1AB, 0);
    idle(20);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    idle(2);
    rst = 1'b1;
    for (int d = 0; d < ND; d++) last_end[d] = 0;
    idle(20);
    for (int d = 0; d < ND; d++) begin
      repeat (12) begin
        g = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, flen(d) + 2));
        send(d, 9'($urandom), g);
      end
      idle(10);
    end
    idle(150);
    done = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
